// File: rtl/cc_microseq_pkg.sv
// Shared definitions for the ARC microsequencer: microword field layout,
// COND encodings, register/ALU codes used by the microprogram, helpers.
package cc_microseq_pkg;

  // Control field offsets are relative to the top of the JUMP field.
  localparam int CTRL_W    = 30;
  localparam int COND_OFF  = 0;
  localparam int COND_W    = 3;
  localparam int ALU_OFF   = 3;
  localparam int ALU_W     = 4;
  localparam int WR_OFF    = 7;
  localparam int RD_OFF    = 8;
  localparam int CMUX_OFF  = 9;
  localparam int C_OFF     = 10;
  localparam int BMUX_OFF  = 16;
  localparam int B_OFF     = 17;
  localparam int AMUX_OFF  = 23;
  localparam int A_OFF     = 24;
  localparam int REG_W     = 6;
  localparam int DEC_W     = 11;

  typedef enum logic [COND_W-1:0] {
    COND_NEXT   = 3'b000,
    COND_N      = 3'b001,
    COND_Z      = 3'b010,
    COND_V      = 3'b011,
    COND_C      = 3'b100,
    COND_IR13   = 3'b101,
    COND_JUMP   = 3'b110,
    COND_DECODE = 3'b111
  } cond_e;

  localparam logic [REG_W-1:0] R_PC    = 6'd32;
  localparam logic [REG_W-1:0] R_TEMP0 = 6'd33;
  localparam logic [REG_W-1:0] R_IR    = 6'd37;

  localparam logic [ALU_W-1:0] ALU_ADDCC   = 4'b0011;
  localparam logic [ALU_W-1:0] ALU_AND     = 4'b0101;
  localparam logic [ALU_W-1:0] ALU_ADD     = 4'b1000;
  localparam logic [ALU_W-1:0] ALU_LSHIFT2 = 4'b1001;
  localparam logic [ALU_W-1:0] ALU_SIMM13  = 4'b1011;
  localparam logic [ALU_W-1:0] ALU_INCPC   = 4'b1110;

  function automatic logic [CTRL_W-1:0] ctl_bits(
    logic [REG_W-1:0] a, logic amux, logic [REG_W-1:0] b, logic bmux,
    logic [REG_W-1:0] c, logic cmux, logic rd, logic wr,
    logic [ALU_W-1:0] alu, cond_e cond);
    logic [CTRL_W-1:0] w;
    w = '0;
    w[A_OFF +: REG_W]    = a;
    w[AMUX_OFF]          = amux;
    w[B_OFF +: REG_W]    = b;
    w[BMUX_OFF]          = bmux;
    w[C_OFF +: REG_W]    = c;
    w[CMUX_OFF]          = cmux;
    w[RD_OFF]            = rd;
    w[WR_OFF]            = wr;
    w[ALU_OFF +: ALU_W]  = alu;
    w[COND_OFF +: COND_W] = cond;
    return w;
  endfunction

  // Caller truncates to 30+aw bits; only COND=JUMP with JUMP=0 is set.
  function automatic logic [63:0] reset_word(int aw);
    return 64'(COND_JUMP) << (aw + COND_OFF);
  endfunction

  // {1, op, op3, 00}: one 4-word slot per (op, op3) pair.
  function automatic logic [DEC_W-1:0] decode_addr(logic [31:0] ir);
    return {1'b1, ir[31:30], ir[24:19], 2'b00};
  endfunction

endpackage

// File: rtl/cc_microseq_rom.sv
// Combinational control store holding the ARC microprogram; unlisted
// addresses return an all-zero word.
module cc_microseq_rom
  import cc_microseq_pkg::*;
#(
  parameter int ADDR_WIDTH = 11
) (
  input  logic [ADDR_WIDTH-1:0]    addr,
  output logic [ADDR_WIDTH+29:0]   word
);

  logic [CTRL_W-1:0]     ctl;
  logic [ADDR_WIDTH-1:0] jmp;

  always_comb begin
    ctl = '0;
    jmp = '0;
    case (addr)
      // fetch: ir <- AND(pc, pc); READ
      ADDR_WIDTH'(0):    ctl = ctl_bits(R_PC, 1'b0, R_PC, 1'b0, R_IR, 1'b0, 1'b1, 1'b0, ALU_AND, COND_NEXT);
      ADDR_WIDTH'(1):    ctl = ctl_bits('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, COND_DECODE);
      ADDR_WIDTH'(2):  begin ctl = ctl_bits('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, COND_IR13); jmp = ADDR_WIDTH'(10); end
      ADDR_WIDTH'(3):  begin ctl = ctl_bits('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, COND_N); jmp = ADDR_WIDTH'(8); end
      ADDR_WIDTH'(4):  begin ctl = ctl_bits('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, COND_Z); jmp = ADDR_WIDTH'(8); end
      ADDR_WIDTH'(5):  begin ctl = ctl_bits('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, COND_V); jmp = ADDR_WIDTH'(8); end
      ADDR_WIDTH'(6):  begin ctl = ctl_bits('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, COND_C); jmp = ADDR_WIDTH'(8); end
      ADDR_WIDTH'(7):  begin ctl = ctl_bits('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, COND_JUMP); jmp = ADDR_WIDTH'(2047); end
      // taken branch: temp0 <- LSHIFT2(ir); pc <- ADD(pc, temp0)
      ADDR_WIDTH'(8):    ctl = ctl_bits(R_IR, 1'b0, '0, 1'b0, R_TEMP0, 1'b0, 1'b0, 1'b0, ALU_LSHIFT2, COND_NEXT);
      ADDR_WIDTH'(9):    ctl = ctl_bits(R_PC, 1'b0, R_TEMP0, 1'b0, R_PC, 1'b0, 1'b0, 1'b0, ALU_ADD, COND_JUMP);
      ADDR_WIDTH'(10):   ctl = ctl_bits(R_TEMP0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, '0, COND_NEXT);
      ADDR_WIDTH'(11):   ctl = ctl_bits(R_TEMP0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1, '0, COND_NEXT);
      ADDR_WIDTH'(12): begin ctl = ctl_bits('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, COND_JUMP); jmp = ADDR_WIDTH'(2047); end
      ADDR_WIDTH'(1088): begin ctl = ctl_bits('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, COND_JUMP); jmp = ADDR_WIDTH'(2); end
      // addcc: register or simm13 second operand
      ADDR_WIDTH'(1600): begin ctl = ctl_bits('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, COND_IR13); jmp = ADDR_WIDTH'(1602); end
      ADDR_WIDTH'(1601): begin ctl = ctl_bits('0, 1'b1, '0, 1'b1, '0, 1'b1, 1'b0, 1'b0, ALU_ADDCC, COND_JUMP); jmp = ADDR_WIDTH'(2047); end
      ADDR_WIDTH'(1602):   ctl = ctl_bits(R_IR, 1'b0, '0, 1'b0, R_TEMP0, 1'b0, 1'b0, 1'b0, ALU_SIMM13, COND_NEXT);
      ADDR_WIDTH'(1603): begin ctl = ctl_bits('0, 1'b1, R_TEMP0, 1'b0, '0, 1'b1, 1'b0, 1'b0, ALU_ADDCC, COND_JUMP); jmp = ADDR_WIDTH'(2047); end
      // pc <- INCPC(pc), then fall through (wraps) to fetch
      ADDR_WIDTH'(2047):   ctl = ctl_bits(R_PC, 1'b0, '0, 1'b0, R_PC, 1'b0, 1'b0, 1'b0, ALU_INCPC, COND_NEXT);
      default: ;
    endcase
  end

  assign word = {ctl, jmp};

endmodule

// File: rtl/cc_microsequencer.sv
// ARC microsequencer: microPC/MIR registers and next-address selection.
// Optional memory-wait stall is compiled in with CC_MICROSEQ_STALL_EN.
module cc_microsequencer
  import cc_microseq_pkg::*;
#(
  parameter int CC_MICROSEQ_ADDR_WIDTH = 11
) (
  input  logic                              CC_MICROSEQ_CLOCK_50,
  input  logic                              CC_MICROSEQ_RESET_InLow,
  input  logic [3:0]                        CC_MICROSEQ_flags_InBUS,
  input  logic [31:0]                       CC_MICROSEQ_ir_InBUS,
  input  logic                              CC_MICROSEQ_memReady_In,
  output logic [CC_MICROSEQ_ADDR_WIDTH+29:0] CC_MICROSEQ_mir_OutBUS,
  output logic [CC_MICROSEQ_ADDR_WIDTH-1:0]  CC_MICROSEQ_upc_OutBUS
);

  localparam int AW = CC_MICROSEQ_ADDR_WIDTH;
  localparam int WW = CTRL_W + AW;
  localparam logic [63:0]   RST_FULL   = reset_word(AW);
  localparam logic [WW-1:0] RESET_WORD = RST_FULL[WW-1:0];

  logic [AW-1:0] upc, next_upc, jump;
  logic [WW-1:0] mir, cs_word;
  logic [3:0]    flags;
  cond_e         cond;
  logic          advance;

  assign flags = CC_MICROSEQ_flags_InBUS;
  assign jump  = mir[AW-1:0];
  assign cond  = cond_e'(mir[AW+COND_OFF +: COND_W]);

  // flags are {N,Z,V,C}
  always_comb begin
    next_upc = upc + AW'(1);
    case (cond)
      COND_N:      if (flags[3]) next_upc = jump;
      COND_Z:      if (flags[2]) next_upc = jump;
      COND_V:      if (flags[1]) next_upc = jump;
      COND_C:      if (flags[0]) next_upc = jump;
      COND_IR13:   if (CC_MICROSEQ_ir_InBUS[13]) next_upc = jump;
      COND_JUMP:   next_upc = jump;
      COND_DECODE: next_upc = AW'(decode_addr(CC_MICROSEQ_ir_InBUS));
      default: ;
    endcase
  end

  cc_microseq_rom #(.ADDR_WIDTH(AW)) u_rom (
    .addr (next_upc),
    .word (cs_word)
  );

`ifdef CC_MICROSEQ_STALL_EN
  logic mem_op;
  assign mem_op  = mir[AW+RD_OFF] | mir[AW+WR_OFF];
  assign advance = !(mem_op && !CC_MICROSEQ_memReady_In);
`else
  logic unused_ready;
  assign unused_ready = CC_MICROSEQ_memReady_In;
  assign advance      = 1'b1;
`endif

  always_ff @(posedge CC_MICROSEQ_CLOCK_50 or negedge CC_MICROSEQ_RESET_InLow) begin
    if (!CC_MICROSEQ_RESET_InLow) begin
      upc <= '0;
      mir <= RESET_WORD;
    end else if (advance) begin
      upc <= next_upc;
      mir <= cs_word;
    end
  end

  assign CC_MICROSEQ_mir_OutBUS = mir;
  assign CC_MICROSEQ_upc_OutBUS = upc;

endmodule
